// File: rtl/seg7_pkg.sv
// Shared seven-segment character table and capture types. The display driver
// and seg7_capture both use encode()/decode() so the two ends cannot disagree.
package seg7_pkg;

  typedef logic [4:0] char_t;
  typedef logic [6:0] seg_t;   // {g,f,e,d,c,b,a}, active-high

  localparam char_t CHAR_0       = 5'd0;
  localparam char_t CHAR_9       = 5'd9;
  localparam char_t CHAR_A       = 5'd10;
  localparam char_t CHAR_B       = 5'd11;
  localparam char_t CHAR_C       = 5'd12;
  localparam char_t CHAR_D       = 5'd13;
  localparam char_t CHAR_E       = 5'd14;
  localparam char_t CHAR_F       = 5'd15;
  localparam char_t CHAR_G       = 5'd16;
  localparam char_t CHAR_H       = 5'd17;
  localparam char_t CHAR_I       = 5'd18;
  localparam char_t CHAR_J       = 5'd19;
  localparam char_t CHAR_L       = 5'd20;
  localparam char_t CHAR_N       = 5'd21;
  localparam char_t CHAR_O       = 5'd22;
  localparam char_t CHAR_P       = 5'd23;
  localparam char_t CHAR_R       = 5'd24;
  localparam char_t CHAR_T       = 5'd25;
  localparam char_t CHAR_U       = 5'd26;
  localparam char_t CHAR_Y       = 5'd27;
  localparam char_t CHAR_HL      = 5'd28;  // lower-case h
  localparam char_t CHAR_CL      = 5'd29;  // lower-case c
  localparam char_t CHAR_UNKNOWN = 5'd30;
  localparam char_t CHAR_BLANK   = 5'd31;

  localparam int unsigned NUM_MAPPED = 30;

  // Indexed by character code; every mapped entry is unique so decode is exact.
  localparam seg_t SEG_TABLE [32] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
    7'h38, 7'h54, 7'h5C, 7'h73, 7'h50, 7'h78, 7'h3E, 7'h6E, 7'h74, 7'h58,
    7'h40, 7'h00
  };

  typedef enum logic {ST_IDLE, ST_SETTLE} cap_state_t;

  function automatic seg_t encode(input char_t c);
    return SEG_TABLE[c];
  endfunction

  function automatic char_t decode(input seg_t p);
    char_t d;
    d = (p == 7'h00) ? CHAR_BLANK : CHAR_UNKNOWN;
    for (int i = 0; i < NUM_MAPPED; i++)
      if (p == SEG_TABLE[i]) d = char_t'(i);
    return d;
  endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Character output channel of seg7_capture: valid/ready head plus status.
interface seg7_capture_if;
  import seg7_pkg::*;

  char_t char_out;
  logic  char_valid;
  logic  char_ready;
  logic  char_unknown;
  logic  overflow;

  modport master (output char_out, char_valid, char_unknown, overflow, input char_ready);
  modport slave  (input char_out, char_valid, char_unknown, overflow, output char_ready);
endinterface

// File: rtl/seg7_capture_fifo.sv
// Small synchronous FIFO for captured characters. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; otherwise o_drop.
module seg7_capture_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_push, w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/seg7_capture.sv
// Segment-bus capture: debounce pattern changes, decode to character codes,
// buffer them. Optional feature macro: SEG7_CAPTURE_REPEAT_EN (periodic re-emit).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [6:0]     segments_in,
  seg7_capture_if.master cap
);
  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("seg7_capture: illegal parameter value");
  end

  cap_state_t    r_state;
  seg_t          r_sample, r_last_acc, r_cand;
  logic [CW-1:0] r_cnt;
  logic          r_push;
  logic [5:0]    r_push_data;   // {unknown, code}
  logic          r_overflow;

  logic [5:0]    w_head;
  logic          w_full, w_empty, w_drop;

`ifdef SEG7_CAPTURE_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] r_rpt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sample    <= '0;
      r_last_acc  <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
`ifdef SEG7_CAPTURE_REPEAT_EN
      r_rpt       <= '0;
`endif
    end else begin
      r_sample <= segments_in;
      r_push   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_sample != r_last_acc) begin
            r_state <= ST_SETTLE;
            r_cand  <= r_sample;
            r_cnt   <= CNT_ONE;
`ifdef SEG7_CAPTURE_REPEAT_EN
            r_rpt   <= '0;
          end else if (r_rpt == RPT_LAST) begin
            // Unchanged pattern long enough: likely a doubled character.
            r_rpt <= '0;
            if (r_last_acc != 7'h00) begin
              r_push      <= 1'b1;
              r_push_data <= {decode(r_last_acc) == CHAR_UNKNOWN, decode(r_last_acc)};
            end
          end else begin
            r_rpt <= r_rpt + RW'(1);
`endif
          end
        end
        ST_SETTLE: begin
          // A glitch that reverts to the accepted pattern is silently dropped.
          if (r_sample == r_last_acc) begin
            r_state <= ST_IDLE;
          end else if (r_sample != r_cand) begin
            r_cand <= r_sample;
            r_cnt  <= CNT_ONE;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_IDLE;
            r_last_acc  <= r_cand;
            r_push      <= 1'b1;
            r_push_data <= {decode(r_cand) == CHAR_UNKNOWN, decode(r_cand)};
`ifdef SEG7_CAPTURE_REPEAT_EN
            r_rpt       <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else       r_overflow <= r_overflow | w_drop;
  end

  seg7_capture_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(6)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (cap.char_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // Head is masked while empty so the outputs read zero out of reset.
  assign cap.char_valid   = !w_empty;
  assign cap.char_out     = w_empty ? '0 : w_head[4:0];
  assign cap.char_unknown = !w_empty && w_head[5];
  assign cap.overflow     = r_overflow;

  logic w_unused;
  assign w_unused = w_full;
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, glitch rejection, decode, overflow,
// full-FIFO push/pop and (when SEG7_CAPTURE_REPEAT_EN) repeat behaviour.
module tb_seg7_capture;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  int         n_checks = 0;
  int         n_fail   = 0;

  seg7_capture_if cap_if ();

  seg7_capture #(.STABLE_CYCLES(16), .FIFO_DEPTH(4), .REPEAT_CYCLES(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .segments_in (seg),
    .cap         (cap_if.master)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    step(n);
  endtask

  task automatic pop();
    cap_if.char_ready = 1'b1;
    step(1);
    cap_if.char_ready = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    seg   = 7'h00;
    cap_if.char_ready = 1'b0;
    step(3);
    chk("rst_valid", cap_if.char_valid, 0);
    chk("rst_out", cap_if.char_out, 0);
    chk("rst_unknown", cap_if.char_unknown, 0);
    chk("rst_overflow", cap_if.overflow, 0);

    // Basic capture: 3F first seen at edge 0, valid after edge 17.
    reset = 1'b0;
    seg   = 7'h3F;
    step(17);
    chk("lat_valid_early", cap_if.char_valid, 0);
    step(1);
    chk("lat_valid", cap_if.char_valid, 1);
    chk("lat_out", cap_if.char_out, 0);
    chk("lat_unknown", cap_if.char_unknown, 0);
    pop();
    chk("lat_empty", cap_if.char_valid, 0);

    // Glitch rejection
    hold(7'h06, 20);
    chk("g_out1", cap_if.char_out, 1);
    pop();
    hold(7'h5B, 10);
    hold(7'h06, 20);
    chk("g_no_push", cap_if.char_valid, 0);
    hold(7'h5B, 20);
    chk("g_valid", cap_if.char_valid, 1);
    chk("g_out2", cap_if.char_out, 2);
    pop();
    chk("g_one_push", cap_if.char_valid, 0);

    // Unknown pattern
    hold(7'h7F, 20);
    hold(7'h49, 20);
    chk("u_out8", cap_if.char_out, 8);
    chk("u_unk8", cap_if.char_unknown, 0);
    pop();
    chk("u_out30", cap_if.char_out, 30);
    chk("u_unk30", cap_if.char_unknown, 1);
    pop();
    chk("u_empty", cap_if.char_valid, 0);

    // Overflow with ready low
    hold(7'h3F, 20);
    hold(7'h06, 20);
    hold(7'h5B, 20);
    hold(7'h4F, 20);
    chk("o_no_ovf_yet", cap_if.overflow, 0);
    hold(7'h66, 20);
    chk("o_ovf", cap_if.overflow, 1);
    chk("o_head0", cap_if.char_out, 0);
    pop();
    chk("o_head1", cap_if.char_out, 1);
    pop();
    chk("o_head2", cap_if.char_out, 2);
    pop();
    chk("o_head3", cap_if.char_out, 3);
    pop();
    chk("o_empty", cap_if.char_valid, 0);
    chk("o_sticky", cap_if.overflow, 1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("o_rst_ovf", cap_if.overflow, 0);
    chk("o_rst_valid", cap_if.char_valid, 0);

    // Reset mid-settle discards the partial pattern
    hold(7'h79, 8);
    reset = 1'b1;
    seg   = 7'h00;
    step(2);
    reset = 1'b0;
    hold(7'h00, 30);
    chk("r_mid_discard", cap_if.char_valid, 0);

    // Full FIFO, pop in the same cycle as the push
    hold(7'h3F, 20);
    hold(7'h06, 20);
    hold(7'h5B, 20);
    hold(7'h4F, 20);
    seg = 7'h66;
    step(17);
    chk("f_head_before", cap_if.char_out, 0);
    pop();
    chk("f_no_ovf", cap_if.overflow, 0);
    chk("f_head1", cap_if.char_out, 1);
    pop();
    chk("f_head2", cap_if.char_out, 2);
    pop();
    chk("f_head3", cap_if.char_out, 3);
    pop();
    chk("f_head4", cap_if.char_out, 4);
    pop();
    chk("f_empty", cap_if.char_valid, 0);

`ifdef SEG7_CAPTURE_REPEAT_EN
    hold(7'h79, 250);
    hold(7'h00, 250);
    chk("rp_no_ovf", cap_if.overflow, 0);
    chk("rp_e1", cap_if.char_out, 14);
    pop();
    chk("rp_e2", cap_if.char_out, 14);
    pop();
    chk("rp_e3", cap_if.char_out, 14);
    pop();
    chk("rp_blank", cap_if.char_out, 31);
    pop();
    chk("rp_empty", cap_if.char_valid, 0);
`else
    hold(7'h79, 250);
    chk("nr_e", cap_if.char_out, 14);
    pop();
    chk("nr_single", cap_if.char_valid, 0);
    hold(7'h00, 30);
    chk("nr_blank", cap_if.char_out, 31);
    pop();
    chk("nr_empty", cap_if.char_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the seven-segment name display driver. Watches a 7-bit segment bus and debounces pattern changes. Decodes each settled pattern back to a 5-bit character code and buffers the codes in a small FIFO behind a valid/ready interface. Used for on-chip loopback self-test of the display path and for reading back which name/digit sequence is being shown.

## Interface

Parameters:
- `STABLE_CYCLES`, 16 — consecutive identical samples required before a pattern is accepted; legal range 2..65535.
- `FIFO_DEPTH`, 4 — character buffer entries; power of two, 2..16.
- `REPEAT_CYCLES`, 10_000_000 — re-emit period for an unchanged pattern; only used when `SEG7_CAPTURE_REPEAT_EN` is defined.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `segments_in` in 7 — segment bus {g,f,e,d,c,b,a}, active-high.
- `char_out` out 5 — character code at FIFO head.
- `char_valid` out 1 — FIFO non-empty.
- `char_ready` in 1 — consumer pops the head when `char_valid && char_ready`.
- `char_unknown` out 1 — head entry decoded as `CHAR_UNKNOWN`.
- `overflow` out 1 — sticky; set when an accepted character was dropped because the FIFO was full.

## Operation

- **Input stage:** `segments_in` is registered once into `sample`. All logic uses `sample`.
- **`last_acc` register:** holds the last accepted pattern; resets to 7'h00 (blank).
- **State IDLE:**
  - `sample == last_acc` → stay.
  - Otherwise → SETTLE, with `candidate <= sample` and `cnt <= 1`.
- **State SETTLE:**
  - `sample != candidate` → `candidate <= sample`, `cnt <= 1`. This restarts settling and does not leave SETTLE.
  - `sample == last_acc` during SETTLE → return to IDLE with no push. This covers a glitch that reverts.
  - `cnt == STABLE_CYCLES-1` with `sample == candidate` → accept:
    - `last_acc <= candidate`.
    - Push `decode(candidate)`.
    - Go to IDLE.
  - Otherwise → `cnt <= cnt + 1`.
- **Decode:**
  - Uses the inverse of the team's seg7 character table.
  - Digits 0–9 map to codes 0–9; letters map to 10..29.
  - 7'h00 → `CHAR_BLANK` (31).
  - Any other pattern → `CHAR_UNKNOWN` (30).
  - Blanks are pushed like any other character.
- **FIFO behaviour:**
  - Push when full: the new character is dropped and `overflow` is set.
  - Simultaneous push and pop when full: both succeed and `overflow` is not set.
  - Pop when empty: ignored.
- **Counters:** `cnt` width is clog2(STABLE_CYCLES); it never wraps.
- **Reset mid-operation:**
  - FIFO, state, `last_acc` and `overflow` are cleared immediately.
  - Any partially settled pattern is discarded.

## Timing

- **Reset values:** `char_out` = 0, `char_valid` = 0, `char_unknown` = 0, `overflow` = 0. State = IDLE, `last_acc` = 7'h00.
- **Latency:**
  - A pattern first driven on `segments_in` before edge t and held constant is pushed at edge t+STABLE_CYCLES.
  - `char_valid` rises after edge t+STABLE_CYCLES+1. There is no empty-FIFO bypass.
- **Minimum change spacing:** a pattern held for fewer than STABLE_CYCLES cycles is never pushed.
- **Handshake:**
  - `char_out` and `char_unknown` are stable while `char_valid && !char_ready`.
  - After a pop, the next entry is presented on the following cycle.
- **`overflow` timing:** rises the cycle after the dropped push and stays high until `reset`.

## Configuration

`SEG7_CAPTURE_REPEAT_EN`:
- **Defined:**
  - A repeat timer restarts on every accept.
  - If the pattern stays equal to `last_acc` for REPEAT_CYCLES cycles after an accept, the same code is pushed again and the timer restarts.
  - Blank (7'h00) is never repeated.
  - This recovers doubled letters that the driver shows as one unchanged pattern across consecutive digit slots.
- **Undefined:**
  - No repeat timer.
  - A character is pushed only when the pattern changes.
  - Port list is unchanged.

## Structure

- **Package `seg7_pkg`:**
  - `CHAR_BLANK` = 31 and `CHAR_UNKNOWN` = 30.
  - Character code constants.
  - The pattern↔code table with `encode`/`decode` functions, shared with the display driver so both ends use one table.
  - The capture state enum.
- **Sub-module `seg7_capture_fifo`:**
  - Synchronous FIFO parameterised by depth and width 6: 5-bit code plus 1-bit unknown flag.
  - Provides full/empty and a drop indicator.

## Test plan

- **Basic capture:** STABLE_CYCLES=16, hold 7'h3F from cycle 0 → `char_valid` rises after edge 17, `char_out` = 0, `char_unknown` = 0.
- **Glitch rejection:** after 7'h06 is accepted, drive 7'h5B for 10 cycles, then 7'h06 again → no push. Then hold 7'h5B for 20 cycles → exactly one push, code 2.
- **Unknown pattern:** hold 7'h7F (8) then 7'h49 (unmapped) → pushes code 8, then code 30 with `char_unknown` = 1.
- **Overflow:** FIFO_DEPTH=4, `char_ready`=0, five distinct settled patterns → 4 entries kept in order, `overflow` = 1. Then pop all and apply `reset` → `overflow` = 0, `char_valid` = 0.
- **Full-FIFO simultaneous push/pop:** FIFO full, `char_ready`=1 in the push cycle → no overflow, count stays 4, order preserved.
- **Repeat (`SEG7_CAPTURE_REPEAT_EN`, REPEAT_CYCLES=100):** hold 7'h79 (E) for 250 cycles → three pushes of the E code. Hold 7'h00 for 250 cycles → one `CHAR_BLANK` push only.
